// File: rtl/sd_word_uart_packer.sv
// Buffers 16-bit SDRAM read words in a small FIFO and serialises each word
// into two bytes for the UART TX stage using the rdy / dout_vld handshake.
//
// state | meaning
// IDLE  | FIFO empty, waiting for a word
// POP   | head word moved into word_r
// B0    | waiting for rdy to emit the first byte
// B0_G  | guard cycle while TX drops rdy
// B1    | waiting for rdy to emit the second byte
// B1_G  | guard cycle, then next word or idle
module sd_word_uart_packer #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   din,
  input  logic          din_vld,
  input  logic          rdy,
  output logic [7:0]    dout,
  output logic          dout_vld,
  output logic [AW:0]   level,
  output logic          empty,
  output logic          full,
  output logic          ovf,
  input  logic          ovf_clr
);

  typedef enum logic [2:0] {IDLE, POP, B0, B0_G, B1, B1_G} state_t;

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  state_t         state, state_nxt;
  logic [15:0]    mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [15:0]    word_r;
  logic [7:0]     byte_first, byte_second;
  logic           pop, push, emit0, emit1;

  assign empty = (level == '0);
  assign full  = (level == LVL_FULL);
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push  = din_vld && (!full || pop);

  assign byte_first  = (MSB_FIRST != 0) ? word_r[15:8] : word_r[7:0];
  assign byte_second = (MSB_FIRST != 0) ? word_r[7:0]  : word_r[15:8];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    emit0     = 1'b0;
    emit1     = 1'b0;
    case (state)
      IDLE: if (!empty) state_nxt = POP;
      POP: begin
        pop       = 1'b1;
        state_nxt = B0;
      end
      B0: if (rdy) begin
        emit0     = 1'b1;
        state_nxt = B0_G;
      end
      B0_G: state_nxt = B1;
      B1: if (rdy) begin
        emit1     = 1'b1;
        state_nxt = B1_G;
      end
      B1_G: state_nxt = empty ? IDLE : POP;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      ovf      <= 1'b0;
      word_r   <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        word_r <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (ovf_clr)                     ovf <= 1'b0;
      else if (din_vld && full && !pop) ovf <= 1'b1;
      dout_vld <= emit0 | emit1;
      if (emit0)      dout <= byte_first;
      else if (emit1) dout <= byte_second;
    end
  end

endmodule
